seq_modn_detector: RTL

Serial MSB-first divisibility detector for a parametrised modulus MOD. Each valid input bit is appended to the running binary number, and the block reports the running remainder and a registered divisible-by-MOD flag. Frame-start and synchronous-clear controls allow several independent numbers to be streamed back to back. It sits on serial bit streams after a deserializer or bit-slicer.

---
 rtl/seq_modn_pkg.sv | 17 +
 rtl/seq_modn_detector_modn_step.sv | 23 ++
 rtl/seq_modn_detector.sv | 96 +++++++++
 3 files changed

// File: rtl/seq_modn_pkg.sv
// rtl/seq_modn_pkg.sv - shared limits, width helper and types for the mod-N detector
package seq_modn_pkg;

    localparam int MOD_MIN = 2;
    localparam int MOD_MAX = 256;

    // Remainder width; MOD=2 still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int RW_MAX = clog2_min1(MOD_MAX);

    // Widest {remainder, bit} intermediate over all legal moduli.
    typedef logic [RW_MAX:0] rem_wide_t;

endpackage

// File: rtl/seq_modn_detector_modn_step.sv
// rtl/seq_modn_detector_modn_step.sv - combinational one-bit remainder update (base, bit) -> nxt
module modn_step
    import seq_modn_pkg::*;
#(
    parameter  int MOD = 3,
    localparam int RW  = clog2_min1(MOD)
) (
    input  logic [RW-1:0] base_i,
    input  logic          bit_i,
    output logic [RW-1:0] nxt_o
);

    logic [RW:0] t;
    logic [RW:0] mod_w;
    logic [RW:0] diff;

    // base < MOD, so 2*base+bit < 2*MOD and one conditional subtract suffices.
    assign mod_w = (RW+1)'(MOD);
    assign t     = {base_i, bit_i};
    assign diff  = t - mod_w;
    assign nxt_o = (t >= mod_w) ? diff[RW-1:0] : t[RW-1:0];

endmodule

// File: rtl/seq_modn_detector.sv
// rtl/seq_modn_detector.sv - serial MSB-first divisibility detector; SEQ_MODN_MATCH_CNT_EN adds a saturating match counter
module seq_modn_detector
    import seq_modn_pkg::*;
#(
    parameter  int MOD   = 3,
    parameter  int CNT_W = 16,
    localparam int RW    = clog2_min1(MOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_bit,
    output logic             out_valid,
    output logic             success,
`ifdef SEQ_MODN_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic [RW-1:0]    rem
);

    if (MOD < MOD_MIN || MOD > MOD_MAX) begin : g_bad_mod
        $error("seq_modn_detector: MOD out of range 2..256");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_modn_detector: CNT_W must be at least 1");
    end

    logic [RW-1:0] rem_q, rem_d;
    logic          success_q, success_d;
    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] base;
    logic [RW-1:0] nxt;

    assign base = in_sof ? '0 : rem_q;

    modn_step #(.MOD(MOD)) u_step (
        .base_i (base),
        .bit_i  (in_bit),
        .nxt_o  (nxt)
    );

    always_comb begin
        rem_d       = rem_q;
        success_d   = 1'b0;
        out_valid_d = 1'b0;
        if (clr) begin
            rem_d = '0;
        end else if (in_valid) begin
            rem_d       = nxt;
            success_d   = (nxt == '0);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            success_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            success_q   <= success_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign rem       = rem_q;
    assign success   = success_q;
    assign out_valid = out_valid_q;

`ifdef SEQ_MODN_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (in_valid && (nxt == '0) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule
